// File: rtl/instr_fetch_stage_if.sv
// Instruction-memory fetch handshake between the IF stage (master) and imem (slave).
interface instr_fetch_stage_if;
    logic        Imem_Req;
    logic [31:0] Imem_Addr;
    logic        Imem_Ack;
    logic [31:0] Imem_Data;

    modport master (output Imem_Req, output Imem_Addr, input Imem_Ack, input Imem_Data);
    modport slave  (input Imem_Req, input Imem_Addr, output Imem_Ack, output Imem_Data);
endinterface

// File: rtl/instr_fetch_stage.sv
// IF stage: PC ownership, single-outstanding imem fetch, prefetch queue, delivery to ID.
// Optional perf counters enabled by defining IF_PERF_CNT_EN.
module instr_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h00400000,
    parameter int unsigned QDEPTH   = 4
) (
    input  logic                        CLK,
    input  logic                        RESET,
    input  logic [31:0]                 Alt_PC,
    input  logic                        Request_Alt_PC,
    input  logic                        WANT_FREEZE,
    instr_fetch_stage_if.master         imem,
    output logic [31:0]                 Instr1_OUT,
    output logic [31:0]                 Instr_PC_OUT,
    output logic [31:0]                 Instr_PC_Plus4_OUT,
    output logic                        Instr_Valid_OUT,
    output logic [31:0]                 Fetch_Count,
    output logic [31:0]                 Freeze_Count
);

    localparam int unsigned AW = $clog2(QDEPTH);
    localparam int unsigned PW = AW + 1;

    typedef enum logic {S_IDLE, S_REQ} state_t;

    state_t          state;
    logic [31:0]     pc;
    logic            discard;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [31:0]     q_instr [QDEPTH];
    logic [31:0]     q_pc    [QDEPTH];

    logic            empty_c;
    logic            ack_c;
    logic            push_c;
    logic            pop_c;
    logic [PW-1:0]   count_c;
    logic [PW-1:0]   count_nxt_c;
    logic            room_c;
    logic [31:0]     alt_pc_c;
    logic [31:0]     pc_nxt_c;

    // Occupancy after this cycle's push/pop/flush decides whether another fetch fits.
    assign empty_c     = (wr_ptr == rd_ptr);
    assign count_c     = wr_ptr - rd_ptr;
    assign ack_c       = (state == S_REQ) && imem.Imem_Ack;
    assign push_c      = ack_c && !discard && !Request_Alt_PC;
    assign pop_c       = !Request_Alt_PC && !WANT_FREEZE && !empty_c;
    assign count_nxt_c = Request_Alt_PC ? '0 : (count_c + PW'(push_c) - PW'(pop_c));
    assign room_c      = (count_nxt_c < PW'(QDEPTH));
    assign alt_pc_c    = Alt_PC & ~32'd3;
    assign pc_nxt_c    = Request_Alt_PC ? alt_pc_c : (push_c ? pc + 32'd4 : pc);

    // Queue payload storage needs no reset; pointers gate what is visible.
    always_ff @(posedge CLK) begin
        if (push_c) begin
            q_instr[wr_ptr[AW-1:0]] <= imem.Imem_Data;
            q_pc[wr_ptr[AW-1:0]]    <= pc;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state              <= S_IDLE;
            pc                 <= RESET_PC;
            discard            <= 1'b0;
            wr_ptr             <= '0;
            rd_ptr             <= '0;
            imem.Imem_Req      <= 1'b0;
            imem.Imem_Addr     <= RESET_PC;
            Instr1_OUT         <= '0;
            Instr_PC_OUT       <= '0;
            Instr_PC_Plus4_OUT <= 32'd4;
            Instr_Valid_OUT    <= 1'b0;
        end else begin
            pc <= pc_nxt_c;

            if (Request_Alt_PC) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push_c) wr_ptr <= wr_ptr + PW'(1);
                if (pop_c)  rd_ptr <= rd_ptr + PW'(1);
            end

            // A redirected in-flight fetch keeps its address and is dropped on ack.
            case (state)
                S_IDLE: begin
                    if (!Request_Alt_PC && room_c) begin
                        state          <= S_REQ;
                        imem.Imem_Req  <= 1'b1;
                        imem.Imem_Addr <= pc_nxt_c;
                    end
                end
                S_REQ: begin
                    if (ack_c) begin
                        discard <= 1'b0;
                        if (!Request_Alt_PC && room_c) begin
                            imem.Imem_Addr <= pc_nxt_c;
                        end else begin
                            state         <= S_IDLE;
                            imem.Imem_Req <= 1'b0;
                        end
                    end else if (Request_Alt_PC) begin
                        discard <= 1'b1;
                    end
                end
                default: begin
                    state         <= S_IDLE;
                    imem.Imem_Req <= 1'b0;
                end
            endcase

            if (Request_Alt_PC) begin
                Instr1_OUT      <= '0;
                Instr_Valid_OUT <= 1'b0;
            end else if (!WANT_FREEZE) begin
                if (pop_c) begin
                    Instr1_OUT         <= q_instr[rd_ptr[AW-1:0]];
                    Instr_PC_OUT       <= q_pc[rd_ptr[AW-1:0]];
                    Instr_PC_Plus4_OUT <= q_pc[rd_ptr[AW-1:0]] + 32'd4;
                    Instr_Valid_OUT    <= 1'b1;
                end else begin
                    Instr1_OUT      <= '0;
                    Instr_Valid_OUT <= 1'b0;
                end
            end
        end
    end

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            Fetch_Count  <= '0;
            Freeze_Count <= '0;
        end else begin
            if (pop_c)       Fetch_Count  <= Fetch_Count + 32'd1;
            if (WANT_FREEZE) Freeze_Count <= Freeze_Count + 32'd1;
        end
    end
`else
    assign Fetch_Count  = 32'd0;
    assign Freeze_Count = 32'd0;
`endif

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Randomized bench for instr_fetch_stage against a queue-based behavioural model.
module tb_instr_fetch_stage;

    localparam int unsigned QDEPTH = 4;
    localparam logic [31:0] RST_PC = 32'h00400000;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] Alt_PC;
    logic        Request_Alt_PC;
    logic        WANT_FREEZE;
    logic [31:0] Instr1_OUT, Instr_PC_OUT, Instr_PC_Plus4_OUT;
    logic        Instr_Valid_OUT;
    logic [31:0] Fetch_Count, Freeze_Count;

    instr_fetch_stage_if imem_bus ();

    instr_fetch_stage #(.RESET_PC(RST_PC), .QDEPTH(QDEPTH)) dut (
        .CLK                (CLK),
        .RESET              (RESET),
        .Alt_PC             (Alt_PC),
        .Request_Alt_PC     (Request_Alt_PC),
        .WANT_FREEZE        (WANT_FREEZE),
        .imem               (imem_bus),
        .Instr1_OUT         (Instr1_OUT),
        .Instr_PC_OUT       (Instr_PC_OUT),
        .Instr_PC_Plus4_OUT (Instr_PC_Plus4_OUT),
        .Instr_Valid_OUT    (Instr_Valid_OUT),
        .Fetch_Count        (Fetch_Count),
        .Freeze_Count       (Freeze_Count)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A0F0F;
    endfunction

    // Reference model state: a program counter, a FIFO of fetched words and the
    // single outstanding request, advanced once per clock.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_pc, m_addr, m_instr, m_opc, m_opc4, m_fc, m_frc;
    logic        m_req, m_discard, m_valid;

    // Memory responder knobs
    int lat       = 0;
    int wait_cnt  = 0;
    bit force_ack = 0;

    task automatic model_tick();
        ent_t h;
        logic acked, push, pop, redir;
        if (!RESET) begin
            mq.delete();
            m_pc = RST_PC; m_addr = RST_PC; m_req = 0; m_discard = 0;
            m_instr = 0; m_opc = 0; m_opc4 = 32'd4; m_valid = 0;
            m_fc = 0; m_frc = 0;
            return;
        end
        redir = Request_Alt_PC;
        acked = m_req && imem_bus.Imem_Ack;
        push  = acked && !m_discard && !redir;
        pop   = !redir && !WANT_FREEZE && (mq.size() > 0);

        if (redir) begin
            m_instr = 0; m_valid = 0;
        end else if (!WANT_FREEZE) begin
            if (pop) begin
                h = mq.pop_front();
                m_instr = h.instr; m_opc = h.pc; m_opc4 = h.pc + 32'd4; m_valid = 1;
                m_fc = m_fc + 32'd1;
            end else begin
                m_instr = 0; m_valid = 0;
            end
        end
        if (WANT_FREEZE) m_frc = m_frc + 32'd1;

        if (redir) mq.delete();
        else if (push) mq.push_back('{instr: imem_bus.Imem_Data, pc: m_pc});

        if (redir) m_pc = {Alt_PC[31:2], 2'b00};
        else if (push) m_pc = m_pc + 32'd4;

        if (m_req) begin
            if (acked) begin
                m_discard = 0;
                if (!redir && mq.size() < QDEPTH) m_addr = m_pc;
                else m_req = 0;
            end else if (redir) begin
                m_discard = 1;
            end
        end else if (!redir && mq.size() < QDEPTH) begin
            m_req = 1; m_addr = m_pc;
        end
    endtask

    task automatic compare_all();
        check_eq("instr", Instr1_OUT, m_instr);
        check_eq("pc", Instr_PC_OUT, m_opc);
        check_eq("pc4", Instr_PC_Plus4_OUT, m_opc4);
        check_eq("valid", 32'(Instr_Valid_OUT), 32'(m_valid));
        check_eq("req", 32'(imem_bus.Imem_Req), 32'(m_req));
        if (m_req) check_eq("addr", imem_bus.Imem_Addr, m_addr);
`ifdef IF_PERF_CNT_EN
        check_eq("fetch_cnt", Fetch_Count, m_fc);
        check_eq("freeze_cnt", Freeze_Count, m_frc);
`else
        check_eq("fetch_cnt", Fetch_Count, 32'd0);
        check_eq("freeze_cnt", Freeze_Count, 32'd0);
`endif
    endtask

    task automatic step(input logic rst_n, input logic fz, input logic rd, input logic [31:0] alt);
        @(negedge CLK);
        RESET          = rst_n;
        WANT_FREEZE    = fz;
        Request_Alt_PC = rd;
        Alt_PC         = alt;
        if (force_ack) begin
            imem_bus.Imem_Ack = 1'b1;
        end else if (imem_bus.Imem_Req) begin
            if (lat < 0 ? ($urandom_range(0, 1) == 1) : (wait_cnt >= lat)) begin
                imem_bus.Imem_Ack = 1'b1;
                wait_cnt = 0;
            end else begin
                imem_bus.Imem_Ack = 1'b0;
                wait_cnt++;
            end
        end else begin
            imem_bus.Imem_Ack = 1'b0;
            wait_cnt = 0;
        end
        imem_bus.Imem_Data = imem_bus.Imem_Ack ? mem_word(imem_bus.Imem_Addr) : $urandom();
        @(posedge CLK);
        model_tick();
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 1'b0, 32'd0);
    endtask

    initial begin
        bit found;
        RESET = 1'b0; WANT_FREEZE = 1'b0; Request_Alt_PC = 1'b0; Alt_PC = '0;
        imem_bus.Imem_Ack = 1'b0; imem_bus.Imem_Data = '0;

        // Reset values against fixed constants
        do_reset();
        check_eq("rst_req", 32'(imem_bus.Imem_Req), 32'd0);
        check_eq("rst_addr", imem_bus.Imem_Addr, 32'h00400000);
        check_eq("rst_instr", Instr1_OUT, 32'd0);
        check_eq("rst_pc", Instr_PC_OUT, 32'd0);
        check_eq("rst_pc4", Instr_PC_Plus4_OUT, 32'd4);
        check_eq("rst_valid", 32'(Instr_Valid_OUT), 32'd0);

        // Zero-latency memory, streaming
        lat = 0;
        repeat (20) step(1'b1, 1'b0, 1'b0, 32'd0);

        // Three-cycle ack latency
        do_reset(); lat = 3;
        repeat (24) step(1'b1, 1'b0, 1'b0, 32'd0);

        // Freeze with fast memory, then release
        do_reset(); lat = 0;
        repeat (3) step(1'b1, 1'b0, 1'b0, 32'd0);
        repeat (5) step(1'b1, 1'b1, 1'b0, 32'd0);
        check_eq("full_noreq", 32'(imem_bus.Imem_Req), 32'd0);
        repeat (10) step(1'b1, 1'b0, 1'b0, 32'd0);

        // Redirect while fetch of 0x0040000C is pending
        do_reset(); lat = 3; found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (m_req && m_addr == 32'h0040000C) found = 1;
            else step(1'b1, 1'b0, 1'b0, 32'd0);
        end
        check_eq("pend_found", 32'(found), 32'd1);
        step(1'b1, 1'b0, 1'b1, 32'h00400100);
        check_eq("redir_nop", 32'(Instr_Valid_OUT), 32'd0);
        repeat (16) step(1'b1, 1'b0, 1'b0, 32'd0);

        // Redirect together with freeze, unaligned target, PC wrap
        lat = 0;
        repeat (4) step(1'b1, 1'b0, 1'b0, 32'd0);
        step(1'b1, 1'b1, 1'b1, 32'hFFFFFFF6);
        repeat (12) step(1'b1, 1'b0, 1'b0, 32'd0);

        // Reset mid-transaction, followed by a stray ack
        lat = 3;
        repeat (2) step(1'b1, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 1'b0, 32'd0);
        force_ack = 1;
        step(1'b1, 1'b0, 1'b0, 32'd0);
        force_ack = 0;
        repeat (10) step(1'b1, 1'b0, 1'b0, 32'd0);

        // Random traffic
        for (int p = 0; p < 8; p++) begin
            lat = int'($urandom_range(0, 4)) - 1;
            for (int c = 0; c < 250; c++) begin
                step(1'b1,
                     ($urandom_range(0, 3) == 0),
                     ($urandom_range(0, 19) == 0),
                     $urandom());
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
